testdata_gen_valid: RTL and testbench
=====================================

Name: testdata_gen_valid

Overview:
Self-checking DDR3 traffic generator/checker. After DDR3 calibration completes, it writes an incrementing data pattern into the controller's write FIFO. It then reads the same number of words back from the read FIFO and compares every word with the expected pattern. A pass flag is raised when all words match; the block sits between the FIFO interfaces of the DDR3 controller and the rest of the board-level test logic.

Parameters:
DATA_WIDTH, 16, width of wr_data/rd_data.
DATA_NUM, 512, number of words written and then read back (at least 2, at most 2^DATA_WIDTH).

Ports:
clk  input  1  system clock, same clock as both FIFO ports
rst  input  1  synchronous reset, active-high
calib_done  input  1  DDR3 initialisation/calibration complete
wr_data  output  DATA_WIDTH  word written to write FIFO
wr_en  output  1  write-FIFO write enable
rd_en  output  1  read-FIFO read enable
rd_mem_enable  output  1  permits controller to read DDR3 into read FIFO
rd_valid  input  1  read FIFO holds data (connect to ~empty)
rd_data  input  DATA_WIDTH  read-FIFO output, standard (non-FWFT) FIFO, valid 1 cycle after rd_en
wr_correct  output  1  all DATA_NUM read words matched the written pattern

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): state=IDLE, all counters 0, error flag 0, wr_en=0, wr_data=0, rd_mem_enable=0, rd_en=0, wr_correct=0.
- Reset mid-operation aborts immediately. The sequence restarts from IDLE; the FIFO contents are the system's responsibility.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE: wait for calib_done=1 sampled at a clk edge, then go to WRITE.
- WRITE:
  - wr_en and wr_data are registered.
  - wr_en=1 for exactly DATA_NUM consecutive cycles, starting the cycle after calib_done is sampled.
  - wr_data = 0, 1, 2, ... DATA_NUM-1, one value per wr_en cycle.
  - Write FIFO full is not monitored; sizing the FIFO is the system's responsibility.
  - After the last word: wr_en=0 and wr_data holds its last value. Go to READ on the next edge.
  - calib_done deasserting during WRITE is ignored.
- READ:
  - rd_mem_enable=1 for the whole state and 0 in all other states.
  - rd_en (combinational) = (state==READ) && rd_valid && (issued_count < DATA_NUM).
  - issued_count increments on each rd_en.
  - rd_en_d (rd_en delayed one cycle) marks rd_data valid.
  - On rd_en_d, rd_data is compared with expected_count (0..DATA_NUM-1). On mismatch the sticky error flag is set. expected_count increments on every compare.
  - Gaps in rd_valid simply stall reads; there is no timeout.
  - Go to DONE when compare number DATA_NUM occurs.
- DONE:
  - rd_en=0, rd_mem_enable=0.
  - wr_correct=1 (registered) iff the error flag is 0. It holds until reset.
  - The block stays in DONE; calib_done is ignored.
- wr_correct is never 1 before all DATA_NUM comparisons complete.
- A mismatch does not stop reading; all DATA_NUM words are still consumed.
- Counters are sized ceil(log2(DATA_NUM+1)) bits; no wrap-around occurs within one run.

Test Plan:
1. Loopback (generator wr_* to FIFO din/wr_en, rd_en to FIFO, rd_valid=~empty), DATA_NUM=512, rst released at 20 ns, calib_done=1 at 620 ns -> wr_en high 512 cycles with data 0..511; then rd_mem_enable=1, 512 rd_en pulses, wr_correct=1 and stays 1.
2. calib_done held 0 for 10 µs -> wr_en, rd_en, rd_mem_enable and wr_correct all remain 0.
3. Loopback, but bit0 of word 100 is forced flipped at the FIFO input -> all 512 reads still occur, FSM reaches DONE, wr_correct stays 0.
4. rd_valid toggled 1/0 every other cycle with a model FIFO -> rd_en only when rd_valid=1, data checked correctly, wr_correct=1.
5. rst asserted while wr_data=200 during WRITE, then released with calib_done still 1 -> outputs are 0 on the reset edge, then the write sequence restarts at wr_data=0.
6. DATA_NUM=2 -> exactly 2 writes (0,1) and 2 reads; wr_correct=1 on the cycle after the second compare.

Source files
------------

// File: rtl/testdata_gen_valid.sv
// rtl/testdata_gen_valid.sv - DDR3 write/read-back pattern generator and checker
module testdata_gen_valid #(
   parameter int DATA_WIDTH = 16,
   parameter int DATA_NUM   = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  calib_done,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic                  rd_mem_enable,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wr_correct
);

   localparam int            CW     = $clog2(DATA_NUM + 1);
   localparam logic [CW-1:0] NUM    = CW'(DATA_NUM);
   localparam logic [CW-1:0] NUM_M1 = CW'(DATA_NUM - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t                state, next_state;
   logic [CW-1:0]         wr_cnt;     // words written so far
   logic [CW-1:0]         iss_cnt;    // read requests issued
   logic [CW-1:0]         cmp_cnt;    // read words compared
   logic [DATA_WIDTH-1:0] exp_data;   // pattern value expected on next compare
   logic                  rd_en_d;    // rd_data is valid this cycle
   logic                  err_flag;   // sticky: some compare failed
   logic                  mismatch;
   logic                  last_cmp;

   assign mismatch = (rd_data != exp_data);
   assign last_cmp = rd_en_d && (cmp_cnt == NUM_M1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state decode plus the combinational read-side strobes
   always_comb begin
      next_state    = state;
      rd_en         = 1'b0;
      rd_mem_enable = 1'b0;
      case (state)
         IDLE:  if (calib_done) next_state = WRITE;
         WRITE: if (wr_cnt == NUM) next_state = READ;
         READ: begin
            rd_mem_enable = 1'b1;
            rd_en         = rd_valid && (iss_cnt < NUM);
            if (last_cmp) next_state = DONE;
         end
         DONE:  next_state = DONE;
         default: next_state = IDLE;
      endcase
   end

   // Write side: first word leaves on the edge that sees calib_done, then one per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_data <= '0;
         wr_cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (calib_done) begin
               wr_en   <= 1'b1;
               wr_data <= '0;
               wr_cnt  <= CW'(1);
            end
            WRITE: if (wr_cnt != NUM) begin
               wr_en   <= 1'b1;
               wr_data <= wr_data + DATA_WIDTH'(1);
               wr_cnt  <= wr_cnt + CW'(1);
            end else begin
               wr_en   <= 1'b0;
            end
            default: wr_en <= 1'b0;
         endcase
      end
   end

   // Read side: count requests, compare the word that arrives one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_cnt    <= '0;
         cmp_cnt    <= '0;
         exp_data   <= '0;
         rd_en_d    <= 1'b0;
         err_flag   <= 1'b0;
         wr_correct <= 1'b0;
      end else begin
         rd_en_d <= rd_en;
         if (rd_en) iss_cnt <= iss_cnt + CW'(1);
         if (rd_en_d) begin
            cmp_cnt  <= cmp_cnt + CW'(1);
            exp_data <= exp_data + DATA_WIDTH'(1);
            if (mismatch) err_flag <= 1'b1;
         end
         // the final compare result is folded in directly so the flag is current on entry to DONE
         if (last_cmp) wr_correct <= !(err_flag || mismatch);
      end
   end

endmodule

// File: tb/tb_testdata_gen_valid.sv
// tb/tb_testdata_gen_valid.sv - scoreboard bench for testdata_gen_valid
module tb_testdata_gen_valid;

   logic        clk = 1'b0;
   logic        rst, calib_done, wr_en, rd_en, rd_mem_enable, rd_valid, wr_correct;
   logic [15:0] wr_data;
   logic [15:0] rd_data = '0;

   logic        rst_s, calib_done_s, wr_en_s, rd_en_s, rd_mem_enable_s, rd_valid_s, wr_correct_s;
   logic [15:0] wr_data_s;
   logic [15:0] rd_data_s = '0;

   int          passed = 0;
   int          total  = 0;
   logic [15:0] exp_q[$];

   logic        toggle_mode = 1'b0;
   logic        corrupt_en  = 1'b0;
   logic        gate;
   int          wptr, rptr, wptr_s, rptr_s;
   logic [15:0] mem   [0:1023];
   logic [15:0] mem_s [0:3];

   always #5 clk = ~clk;

   testdata_gen_valid #(.DATA_WIDTH(16), .DATA_NUM(512)) dut (
      .clk(clk), .rst(rst), .calib_done(calib_done), .wr_data(wr_data), .wr_en(wr_en),
      .rd_en(rd_en), .rd_mem_enable(rd_mem_enable), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_correct(wr_correct)
   );

   testdata_gen_valid #(.DATA_WIDTH(16), .DATA_NUM(2)) dut_s (
      .clk(clk), .rst(rst_s), .calib_done(calib_done_s), .wr_data(wr_data_s), .wr_en(wr_en_s),
      .rd_en(rd_en_s), .rd_mem_enable(rd_mem_enable_s), .rd_valid(rd_valid_s), .rd_data(rd_data_s),
      .wr_correct(wr_correct_s)
   );

   // Standard (non-FWFT) FIFO model with optional corruption of word 100 and rd_valid gating
   always @(posedge clk) begin
      if (rst) begin
         wptr <= 0;
         rptr <= 0;
         gate <= 1'b1;
      end else begin
         if (wr_en) begin
            mem[wptr[9:0]] <= (corrupt_en && wr_data == 16'd100) ? (wr_data ^ 16'd1) : wr_data;
            wptr <= wptr + 1;
         end
         if (rd_en) begin
            rd_data <= mem[rptr[9:0]];
            rptr    <= rptr + 1;
         end
         gate <= toggle_mode ? ~gate : 1'b1;
      end
   end
   assign rd_valid = (wptr != rptr) && gate;

   // Small FIFO model for the DATA_NUM=2 instance
   always @(posedge clk) begin
      if (rst_s) begin
         wptr_s <= 0;
         rptr_s <= 0;
      end else begin
         if (wr_en_s) begin
            mem_s[wptr_s[1:0]] <= wr_data_s;
            wptr_s <= wptr_s + 1;
         end
         if (rd_en_s) begin
            rd_data_s <= mem_s[rptr_s[1:0]];
            rptr_s    <= rptr_s + 1;
         end
      end
   end
   assign rd_valid_s = (wptr_s != rptr_s);

   task automatic test_reset;
      rst = 1'b1; calib_done = 1'b0; rst_s = 1'b1; calib_done_s = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({wr_en, rd_en, rd_mem_enable, wr_correct, wr_data} !== 20'd0)
         $display("FAIL reset_outputs got %h want 0", {wr_en, rd_en, rd_mem_enable, wr_correct, wr_data});
      else passed++;
      total++;
      if ({wr_en_s, rd_en_s, rd_mem_enable_s, wr_correct_s, wr_data_s} !== 20'd0)
         $display("FAIL reset_outputs_small got %h want 0", {wr_en_s, rd_en_s, rd_mem_enable_s, wr_correct_s, wr_data_s});
      else passed++;
   endtask

   task automatic test_no_calib;
      logic seen;
      seen = 1'b0;
      rst = 1'b0; calib_done = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (wr_en || rd_en || rd_mem_enable || wr_correct) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL no_calib_activity got %b want 0", seen);
      else passed++;
   endtask

   task automatic test_loopback(input string name, input logic corrupt, input logic toggle, input logic exp_ok);
      int   wr_seen, rd_seen;
      logic early, bad_rd, timeout, late_rd;
      logic [15:0] e;
      rst = 1'b1; calib_done = 1'b0; corrupt_en = corrupt; toggle_mode = toggle;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      exp_q.delete();
      for (int i = 0; i < 512; i++) exp_q.push_back(16'(i));
      wr_seen = 0; rd_seen = 0; early = 1'b0; bad_rd = 1'b0; timeout = 1'b1; late_rd = 1'b0;
      calib_done = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if (c == 300) calib_done = 1'b0;
         if (wr_en) begin
            wr_seen++;
            total++;
            if (exp_q.size() == 0) $display("FAIL %s extra_write got %0d want none", name, wr_data);
            else begin
               e = exp_q.pop_front();
               if (wr_data !== e) $display("FAIL %s wr_data got %0d want %0d", name, wr_data, e);
               else passed++;
            end
         end
         if (rd_en) begin
            rd_seen++;
            if (!rd_valid || !rd_mem_enable) bad_rd = 1'b1;
         end
         if (wr_correct && rd_seen < 512) early = 1'b1;
         if (rd_seen == 512) begin
            timeout = 1'b0;
            break;
         end
      end
      total++;
      if (timeout !== 1'b0) $display("FAIL %s read_timeout got %0d reads want 512", name, rd_seen);
      else passed++;
      calib_done = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (rd_en || wr_en) late_rd = 1'b1;
      end
      total++;
      if (wr_seen !== 512) $display("FAIL %s write_count got %0d want 512", name, wr_seen);
      else passed++;
      total++;
      if (early !== 1'b0 || bad_rd !== 1'b0 || late_rd !== 1'b0)
         $display("FAIL %s rd_protocol got early=%b bad=%b late=%b want 0", name, early, bad_rd, late_rd);
      else passed++;
      total++;
      if ({rd_mem_enable, wr_correct} !== {1'b0, exp_ok})
         $display("FAIL %s done_flags got %b want %b", name, {rd_mem_enable, wr_correct}, {1'b0, exp_ok});
      else passed++;
      repeat (20) @(negedge clk);
      total++;
      if (wr_correct !== exp_ok) $display("FAIL %s wr_correct_hold got %b want %b", name, wr_correct, exp_ok);
      else passed++;
      corrupt_en = 1'b0; toggle_mode = 1'b0;
   endtask

   task automatic test_reset_mid_write;
      logic found;
      rst = 1'b1; calib_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; calib_done = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (wr_en && wr_data == 16'd200) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (found !== 1'b1) $display("FAIL midwrite_reach200 got %b want 1", found);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({wr_en, rd_mem_enable, rd_en, wr_data} !== 19'd0)
         $display("FAIL midwrite_reset_outputs got %h want 0", {wr_en, rd_mem_enable, rd_en, wr_data});
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({wr_en, wr_data} !== {1'b1, 16'd0}) $display("FAIL midwrite_restart0 got %h want %h", {wr_en, wr_data}, {1'b1, 16'd0});
      else passed++;
      @(negedge clk);
      total++;
      if ({wr_en, wr_data} !== {1'b1, 16'd1}) $display("FAIL midwrite_restart1 got %h want %h", {wr_en, wr_data}, {1'b1, 16'd1});
      else passed++;
      rst = 1'b1; calib_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_min_depth;
      int   wr_seen, rd_seen;
      logic timeout;
      logic [15:0] e;
      rst_s = 1'b1; calib_done_s = 1'b0;
      repeat (2) @(negedge clk);
      rst_s = 1'b0;
      exp_q.delete();
      exp_q.push_back(16'd0);
      exp_q.push_back(16'd1);
      wr_seen = 0; rd_seen = 0; timeout = 1'b1;
      calib_done_s = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (wr_en_s) begin
            wr_seen++;
            total++;
            if (exp_q.size() == 0) $display("FAIL small_extra_write got %0d want none", wr_data_s);
            else begin
               e = exp_q.pop_front();
               if (wr_data_s !== e) $display("FAIL small_wr_data got %0d want %0d", wr_data_s, e);
               else passed++;
            end
         end
         if (rd_en_s) rd_seen++;
         if (rd_seen == 2) begin
            timeout = 1'b0;
            break;
         end
      end
      total++;
      if (timeout !== 1'b0) $display("FAIL small_read_timeout got %0d want 2", rd_seen);
      else passed++;
      @(negedge clk);
      total++;
      if (wr_correct_s !== 1'b0) $display("FAIL small_correct_early got %b want 0", wr_correct_s);
      else passed++;
      @(negedge clk);
      total++;
      if (wr_correct_s !== 1'b1) $display("FAIL small_correct got %b want 1", wr_correct_s);
      else passed++;
      repeat (10) begin
         @(negedge clk);
         if (wr_en_s) wr_seen++;
         if (rd_en_s) rd_seen++;
      end
      total++;
      if (wr_seen !== 2 || rd_seen !== 2) $display("FAIL small_counts got w=%0d r=%0d want 2/2", wr_seen, rd_seen);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_no_calib;
      test_loopback("loopback", 1'b0, 1'b0, 1'b1);
      test_loopback("corrupt", 1'b1, 1'b0, 1'b0);
      test_loopback("gapped", 1'b0, 1'b1, 1'b1);
      test_reset_mid_write;
      test_min_depth;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
